// File: rtl/lbp_host_mem_if.sv
// Host stream, encoder memory port and result stream of lbp_host_mem.
// master = host/encoder side, slave = the memory responder.
interface lbp_host_mem_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic [PIX_W-1:0]  in_data;
  logic              in_ready;
  logic              enc_rst;
  logic [ADDR_W-1:0] gray_addr;
  logic              gray_req;
  logic [PIX_W-1:0]  gray_data;
  logic [ADDR_W-1:0] lbp_addr;
  logic              lbp_write;
  logic [PIX_W-1:0]  lbp_data;
  logic              finish;
  logic              out_valid;
  logic [PIX_W-1:0]  out_data;
  logic              out_ready;
  logic              done;
  logic              err;

  modport master (
    output start, in_valid, in_data, gray_addr, gray_req,
           lbp_addr, lbp_write, lbp_data, finish, out_ready,
    input  in_ready, enc_rst, gray_data, out_valid, out_data, done, err
  );

  modport slave (
    input  start, in_valid, in_data, gray_addr, gray_req,
           lbp_addr, lbp_write, lbp_data, finish, out_ready,
    output in_ready, enc_rst, gray_data, out_valid, out_data, done, err
  );
endinterface

// File: rtl/lbp_host_mem.sv
// Gray-image / LBP-result memory responder between a host stream and the LBP encoder.
// Define LBP_HOST_FULL_FRAME_EN to drain all pixels (border as 0) instead of the interior only.
module lbp_host_mem #(
  parameter int IMG_W = 8,
  parameter int PIX_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  lbp_host_mem_if.slave bus
);
  localparam int ROW_W  = $clog2(IMG_W);
  localparam int ADDR_W = 2 * ROW_W;
  localparam int NPIX   = IMG_W * IMG_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0]  pix_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SERVE, S_DRAIN, S_DONE} state_e;

  localparam addr_t            LAST_PIX    = addr_t'(NPIX - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] COL_LAST_IN = ROW_W'(IMG_W - 2);
`ifdef LBP_HOST_FULL_FRAME_EN
  localparam addr_t DRAIN_FIRST = '0;
  localparam addr_t DRAIN_LAST  = addr_t'(NPIX - 1);
`else
  localparam addr_t DRAIN_FIRST = addr_t'(IMG_W + 1);
  localparam addr_t DRAIN_LAST  = addr_t'((IMG_W - 2) * IMG_W + IMG_W - 2);
`endif

  function automatic logic is_interior(input addr_t a);
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] col;
    row = a[ADDR_W-1:ROW_W];
    col = a[ROW_W-1:0];
    return (row != '0) && (row != ROW_LAST) && (col != '0) && (col != ROW_LAST);
  endfunction

  function automatic addr_t drain_next(input addr_t a);
`ifdef LBP_HOST_FULL_FRAME_EN
    return a + addr_t'(1);
`else
    // From the last interior column hop over the right and next left border.
    return (a[ROW_W-1:0] == COL_LAST_IN) ? a + addr_t'(3) : a + addr_t'(1);
`endif
  endfunction

  state_e          state_q, state_d;
  addr_t           idx_q, idx_d;
  logic [NPIX-1:0] written_q, written_d;
  logic            err_q, err_d;
  logic [9:0]      rd_cnt_q, rd_cnt_d;
  addr_t           drain_addr_q, drain_addr_d;
  logic            out_valid_q, out_valid_d;
  pix_t            out_data_q, out_data_d;

  pix_t gray_mem [NPIX];
  pix_t lbp_mem  [NPIX];

  logic  load_fire;
  logic  wr_hit;
  logic  wr_border;
  logic  missing;
  addr_t drain_rd_addr;
  pix_t  drain_rd_val;

  always_comb begin
    load_fire = (state_q == S_LOAD) && bus.in_valid;
    wr_hit    = (state_q == S_SERVE) && bus.lbp_write && is_interior(bus.lbp_addr);
    wr_border = (state_q == S_SERVE) && bus.lbp_write && !is_interior(bus.lbp_addr);
  end

  // Next result to register; forwards a write landing in the finish cycle.
  always_comb begin
    drain_rd_addr = (state_q == S_SERVE) ? DRAIN_FIRST : drain_next(drain_addr_q);
    if (wr_hit && (bus.lbp_addr == drain_rd_addr)) begin
      drain_rd_val = bus.lbp_data;
    end else if (written_q[drain_rd_addr]) begin
      drain_rd_val = lbp_mem[drain_rd_addr];
    end else begin
      drain_rd_val = '0;
    end
  end

  // NOTE: every _d variable is given its hold value first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    written_d    = written_q;
    err_d        = err_q;
    rd_cnt_d     = rd_cnt_q;
    drain_addr_d = drain_addr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    missing      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_LOAD;
          idx_d     = '0;
          written_d = '0;
          err_d     = 1'b0;
          rd_cnt_d  = '0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          idx_d = idx_q + addr_t'(1);
          if (idx_q == LAST_PIX) state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (bus.gray_req && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 10'd1;
        if (wr_hit) written_d[bus.lbp_addr] = 1'b1;
        if (wr_border) err_d = 1'b1;
        if (bus.finish) begin
          for (int i = 0; i < NPIX; i++) begin
            if (is_interior(addr_t'(i)) && !written_d[i]) missing = 1'b1;
          end
          if (missing) err_d = 1'b1;
          state_d      = S_DRAIN;
          drain_addr_d = DRAIN_FIRST;
          out_valid_d  = 1'b1;
          out_data_d   = drain_rd_val;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          if (drain_addr_q == DRAIN_LAST) begin
            state_d     = S_DONE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
          end else begin
            drain_addr_d = drain_rd_addr;
            out_data_d   = drain_rd_val;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking stays in always_comb.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      written_q    <= '0;
      err_q        <= 1'b0;
      rd_cnt_q     <= '0;
      drain_addr_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      written_q    <= written_d;
      err_q        <= err_d;
      rd_cnt_q     <= rd_cnt_d;
      drain_addr_q <= drain_addr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // NOTE: the memories are not reset; the written bitmap marks which results are valid.
  always_ff @(posedge clk) begin
    if (reset && load_fire) gray_mem[idx_q] <= bus.in_data;
    if (reset && wr_hit)    lbp_mem[bus.lbp_addr] <= bus.lbp_data;
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.enc_rst   = (state_q != S_SERVE);
  assign bus.gray_data = gray_mem[bus.gray_addr];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed self-checking bench for lbp_host_mem: load, serve, drain, errors and reset.
module tb_lbp_host_mem;
  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic [7:0] exp_q [64];
  int   exp_n;

  lbp_host_mem_if #(.PIX_W(8), .ADDR_W(6)) bus_if ();

  lbp_host_mem #(.IMG_W(8), .PIX_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit interior(input int a);
    return (a / 8 >= 1) && (a / 8 <= 6) && (a % 8 >= 1) && (a % 8 <= 6);
  endfunction

  task automatic build_exp(input logic [7:0] xor_v, input int skip);
    exp_n = 0;
    for (int a = 0; a < 64; a++) begin
`ifdef LBP_HOST_FULL_FRAME_EN
      exp_q[exp_n] = (interior(a) && a != skip) ? (8'(a) ^ xor_v) : 8'h00;
      exp_n++;
`else
      if (interior(a)) begin
        exp_q[exp_n] = (a != skip) ? (8'(a) ^ xor_v) : 8'h00;
        exp_n++;
      end
`endif
    end
  endtask

  task automatic feed_pixels(input int base);
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus_if.in_data = 8'(base + i);
      step(1);
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic load_image(input int base);
    bus_if.start = 1'b1;
    step(1);
    bus_if.start = 1'b0;
    feed_pixels(base);
  endtask

  task automatic write_lbp(input int a, input logic [7:0] d, input bit fin);
    bus_if.lbp_addr  = 6'(a);
    bus_if.lbp_data  = d;
    bus_if.lbp_write = 1'b1;
    bus_if.finish    = fin;
    step(1);
    bus_if.lbp_write = 1'b0;
    bus_if.finish    = 1'b0;
  endtask

  task automatic write_interior(input logic [7:0] xor_v, input int skip);
    for (int a = 0; a < 64; a++) begin
      if (interior(a) && a != skip) write_lbp(a, 8'(a) ^ xor_v, 1'b0);
    end
  endtask

  task automatic pulse_finish();
    bus_if.finish = 1'b1;
    step(1);
    bus_if.finish = 1'b0;
  endtask

  // Called the cycle after finish was sampled; walks the stream against exp_q.
  task automatic drain_check(input string name, input bit toggle, input int exp_cycles);
    int k   = 0;
    int cyc = 0;
    tests_run++;
    if (bus_if.out_valid !== 1'b1 || bus_if.enc_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_entry: out_valid=%b enc_rst=%b, expected 1 1", name, bus_if.out_valid, bus_if.enc_rst);
    end
    while (k < exp_n && cyc < 300) begin
      bus_if.out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      tests_run++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL %s_entry%0d: valid=%b data=%h, expected valid=1 data=%h", name, k, bus_if.out_valid, bus_if.out_data, exp_q[k]);
      end
      if (bus_if.out_ready) k++;
      step(1);
      cyc++;
    end
    bus_if.out_ready = 1'b0;
    tests_run++;
    if (k != exp_n || cyc != exp_cycles) begin
      tests_failed++;
      $display("FAIL %s_length: %0d entries in %0d cycles, expected %0d in %0d", name, k, cyc, exp_n, exp_cycles);
    end
    tests_run++;
    if (bus_if.done !== 1'b1 || bus_if.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_done: done=%b out_valid=%b, expected 1 0", name, bus_if.done, bus_if.out_valid);
    end
    step(1);
    tests_run++;
    if (bus_if.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_done_pulse: done=%b, expected 0", name, bus_if.done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    tests_run++;
    if (bus_if.in_ready !== 1'b0 || bus_if.enc_rst !== 1'b1 || bus_if.out_valid !== 1'b0 ||
        bus_if.out_data !== 8'h00 || bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: in_ready=%b enc_rst=%b out_valid=%b out_data=%h done=%b err=%b, expected 0 1 0 00 0 0",
               bus_if.in_ready, bus_if.enc_rst, bus_if.out_valid, bus_if.out_data, bus_if.done, bus_if.err);
    end
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_load();
    bus_if.start = 1'b1;
    step(1);
    bus_if.start = 1'b0;
    tests_run++;
    if (bus_if.in_ready !== 1'b1 || bus_if.enc_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_start: in_ready=%b enc_rst=%b, expected 1 1", bus_if.in_ready, bus_if.enc_rst);
    end
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus_if.in_data = 8'(i);
      if (i == 63) begin
        tests_run++;
        if (bus_if.enc_rst !== 1'b1) begin
          tests_failed++;
          $display("FAIL load_last_pixel: enc_rst=%b, expected 1", bus_if.enc_rst);
        end
      end
      step(1);
    end
    bus_if.in_valid = 1'b0;
    tests_run++;
    if (bus_if.enc_rst !== 1'b0 || bus_if.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_to_serve: enc_rst=%b in_ready=%b, expected 0 0", bus_if.enc_rst, bus_if.in_ready);
    end
    bus_if.gray_addr = 6'd9;
    #1;
    tests_run++;
    if (bus_if.gray_data !== 8'd9) begin
      tests_failed++;
      $display("FAIL gray_read_9: got %0d, expected 9", bus_if.gray_data);
    end
    bus_if.gray_addr = 6'd63;
    #1;
    tests_run++;
    if (bus_if.gray_data !== 8'd63) begin
      tests_failed++;
      $display("FAIL gray_read_63: got %0d, expected 63", bus_if.gray_data);
    end
    bus_if.gray_req = 1'b1;
    step(5);
    bus_if.gray_req = 1'b0;
    tests_run++;
    if (dut.rd_cnt_q !== 10'd5) begin
      tests_failed++;
      $display("FAIL rd_cnt_5: got %0d, expected 5", dut.rd_cnt_q);
    end
  endtask

  task automatic test_drain_full();
    write_interior(8'h00, 9);
    write_lbp(9, 8'd9, 1'b1);
    build_exp(8'h00, -1);
    drain_check("drain_full", 1'b0, exp_n);
    tests_run++;
    if (bus_if.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_full_err: err=%b, expected 0", bus_if.err);
    end
  endtask

  task automatic test_backpressure();
    load_image(0);
    tests_run++;
    if (dut.rd_cnt_q !== 10'd0) begin
      tests_failed++;
      $display("FAIL rd_cnt_clear: got %0d, expected 0", dut.rd_cnt_q);
    end
    bus_if.gray_req = 1'b1;
    step(1030);
    bus_if.gray_req = 1'b0;
    tests_run++;
    if (dut.rd_cnt_q !== 10'd1023) begin
      tests_failed++;
      $display("FAIL rd_cnt_saturate: got %0d, expected 1023", dut.rd_cnt_q);
    end
    write_interior(8'hA5, -1);
    pulse_finish();
    build_exp(8'hA5, -1);
    drain_check("backpressure", 1'b1, 2 * exp_n);
  endtask

  task automatic test_border_write();
    load_image(8'h40);
    write_lbp(0, 8'h77, 1'b0);
    tests_run++;
    if (bus_if.err !== 1'b1 || dut.written_q[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL border_write: err=%b written0=%b, expected 1 0", bus_if.err, dut.written_q[0]);
    end
    bus_if.start = 1'b1;
    step(1);
    bus_if.start = 1'b0;
    tests_run++;
    if (bus_if.enc_rst !== 1'b0 || bus_if.err !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_ignored: enc_rst=%b err=%b, expected 0 1", bus_if.enc_rst, bus_if.err);
    end
    write_interior(8'h3C, -1);
    pulse_finish();
    build_exp(8'h3C, -1);
    drain_check("border", 1'b0, exp_n);
    tests_run++;
    if (bus_if.err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: err=%b, expected 1", bus_if.err);
    end
    bus_if.start = 1'b1;
    step(1);
    bus_if.start = 1'b0;
    tests_run++;
    if (bus_if.err !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_clears_err: err=%b in_ready=%b, expected 0 1", bus_if.err, bus_if.in_ready);
    end
  endtask

  task automatic test_missing();
    feed_pixels(0);
    write_interior(8'h11, 27);
    tests_run++;
    if (bus_if.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL missing_pre: err=%b, expected 0", bus_if.err);
    end
    pulse_finish();
    tests_run++;
    if (bus_if.err !== 1'b1) begin
      tests_failed++;
      $display("FAIL missing_err: err=%b, expected 1", bus_if.err);
    end
    build_exp(8'h11, 27);
    drain_check("missing", 1'b0, exp_n);
  endtask

  task automatic test_reset_mid_load();
    bus_if.start = 1'b1;
    step(1);
    bus_if.start    = 1'b0;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_if.in_data = 8'(200 + i);
      step(1);
    end
    reset = 1'b0;
    step(1);
    reset           = 1'b1;
    bus_if.in_valid = 1'b0;
    tests_run++;
    if (bus_if.in_ready !== 1'b0 || bus_if.enc_rst !== 1'b1 || bus_if.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_load_reset: in_ready=%b enc_rst=%b err=%b, expected 0 1 0", bus_if.in_ready, bus_if.enc_rst, bus_if.err);
    end
    step(1);
    load_image(50);
    for (int a = 0; a < 64; a += 20) begin
      bus_if.gray_addr = 6'(a);
      #1;
      tests_run++;
      if (bus_if.gray_data !== 8'(50 + a)) begin
        tests_failed++;
        $display("FAIL reload_addr%0d: got %0d, expected %0d", a, bus_if.gray_data, 50 + a);
      end
    end
  endtask

  initial begin
    reset            = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.gray_addr = '0;
    bus_if.gray_req  = 1'b0;
    bus_if.lbp_addr  = '0;
    bus_if.lbp_write = 1'b0;
    bus_if.lbp_data  = '0;
    bus_if.finish    = 1'b0;
    bus_if.out_ready = 1'b0;
    test_reset();
    test_load();
    test_drain_full();
    test_backpressure();
    test_border_write();
    test_missing();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
